freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures an external slow square wave, such as the output of a divided clock or a pushbutton-derived test signal, against the 100 MHz system clock.
- Reports two results:
  - rising-edge count per fixed gate window (frequency);
  - clock-cycle distance between consecutive rising edges (period).
- Sits between a board input pin or internal divided clock and the display/readout logic.
- Lets the team check divider outputs in hardware.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk100MHz cycles (1 s at 100 MHz)
- CNT_W, 27, width of edge counter / freq_count
- PER_W, 32, width of period counter / period_count
- TIMEOUT_CYCLES, 200000000, cycles without an edge before no_signal asserts

Ports:
- clk100MHz  input  1  system clock, 100 MHz, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- sig_in  input  1  measured signal, asynchronous to clk100MHz
- enable  input  1  1 = measure; 0 = halt and clear in-progress measurements
- freq_count  output  CNT_W  rising edges counted in last completed window
- freq_valid  output  1  one-cycle pulse when freq_count updates
- freq_ovf  output  1  last window's edge count saturated
- period_count  output  PER_W  cycles between last two detected rising edges
- period_valid  output  1  one-cycle pulse when period_count updates
- no_signal  output  1  no edge seen for TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0 at a clock edge):
  - all internal counters cleared; period FSM to IDLE;
  - outputs: freq_count=0, freq_valid=0, freq_ovf=0, period_count=0, period_valid=0, no_signal=1.
  - Reset has priority over every other event, including a window end on the same cycle.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a third flop.
  - edge = s2 & ~s3.
  - Latency: a sig_in rise is seen as edge 2-3 cycles later.
  - A pulse shorter than one clock period may be missed; this is acceptable.
- Gate timer:
  - While enable=1, gate_cnt runs 0..GATE_CYCLES-1 and wraps.
  - On the terminal cycle (gate_cnt=GATE_CYCLES-1):
    - freq_count <= edge_cnt + edge, saturating at 2^CNT_W-1;
    - freq_ovf <= 1 if saturation occurred, else 0;
    - freq_valid=1 for exactly that cycle;
    - edge_cnt <= 0.
  - An edge on the terminal cycle belongs to the closing window.
  - edge_cnt increments on edge, saturates, and never wraps.
- Enable low:
  - gate_cnt, edge_cnt and per_cnt held at 0; period FSM forced to IDLE; no valid pulses.
  - freq_count, freq_ovf, period_count and no_signal hold their last values.
  - After enable rises, the first freq_valid comes exactly GATE_CYCLES cycles later.
- Period FSM:
  - IDLE:
    - edge -> MEASURE, per_cnt <= 0, no_signal <= 0;
    - no period_valid.
  - MEASURE:
    - each cycle per_cnt increments;
    - on edge: period_count <= per_cnt+1 (the exact cycle distance between edges), period_valid=1 for one cycle, per_cnt <= 0;
    - if per_cnt reaches TIMEOUT_CYCLES-1 with no edge: -> IDLE, no_signal <= 1, period_count holds.
  - Edge and timeout on the same cycle: the edge wins.
  - per_cnt never exceeds TIMEOUT_CYCLES-1. TIMEOUT_CYCLES must be ≤ 2^PER_W-1.
- freq_valid and period_valid are independent and may pulse on the same cycle.

Test Plan:
- Sim params GATE_CYCLES=1000, TIMEOUT_CYCLES=50.
  - Stimulus: sig_in square wave, period 10 cycles.
  - Response: from the 2nd window on, freq_count=100 and freq_ovf=0; freq_valid exactly 1 cycle every 1000 cycles.
- Same stimulus:
  - Response: first period_valid at the 2nd detected edge; every period_count=10; period_valid every 10 cycles; no_signal falls at the 1st edge.
- CNT_W=4, GATE_CYCLES=1000, sig_in period 10 (100 edges):
  - Response: freq_count=15, freq_ovf=1.
  - Then 8 edges in the next window -> freq_count=8, freq_ovf=0.
- Stop sig_in (held low) after an edge:
  - Response: no_signal=1 after 50 cycles, FSM in IDLE, period_count keeps 10.
  - Resume -> no_signal=0 at the 1st edge, next period_valid at the 2nd edge.
- Edge placed so that it is detected on gate_cnt=999:
  - Response: that edge is counted in the closing window's freq_count, not the next.
- Disturbance tests:
  - rst=0 for one cycle mid-window -> all outputs take reset values, with no_signal=1; the next freq_valid comes 1000 cycles after rst returns high.
  - enable=0 mid-window -> no freq_valid and outputs hold; re-enable -> freq_valid exactly 1000 cycles later.

Source files
------------

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - edge-count frequency and edge-to-edge period meter for a slow external signal
//
// Purpose:
//   Measures a slow square wave against the 100 MHz system clock and reports
//   the number of rising edges seen in each gate window (frequency) and the
//   clock-cycle distance between consecutive rising edges (period).
//
// Ports:
//   clk100MHz     in   1      system clock, all logic on its rising edge
//   rst           in   1      synchronous active-low reset
//   sig_in        in   1      measured signal, asynchronous to clk100MHz
//   enable        in   1      1 = measure, 0 = halt and clear in-progress work
//   freq_count    out  CNT_W  rising edges counted in the last completed window
//   freq_valid    out  1      one-cycle pulse when freq_count updates
//   freq_ovf      out  1      last window's edge count saturated
//   period_count  out  PER_W  cycles between the last two detected rising edges
//   period_valid  out  1      one-cycle pulse when period_count updates
//   no_signal     out  1      no edge seen for TIMEOUT_CYCLES cycles

`timescale 1ns / 1ps

module freq_meter #(
    parameter int GATE_CYCLES    = 100000000,
    parameter int CNT_W          = 27,
    parameter int PER_W          = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic             clk100MHz,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic [PER_W-1:0] period_count,
    output logic             period_valid,
    output logic             no_signal
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchronizer plus one delay flop.
    // These flops are deliberately left out of reset; they flush within
    // three cycles and keeping them running avoids a false edge when
    // reset is released while sig_in is already high.
    // ------------------------------------------------------------------
    logic s1;
    logic s2;
    logic s3;
    logic sig_edge;

    always_ff @(posedge clk100MHz) begin
        s1 <= sig_in;
        s2 <= s1;
        s3 <= s2;
    end

    assign sig_edge = s2 & ~s3;

    // ------------------------------------------------------------------
    // Gate timer and edge counter
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_sat;   // an edge arrived while edge_cnt was already full
    logic              gate_end;
    logic              cnt_full;

    assign gate_end = (gate_cnt == GATE_LAST);
    assign cnt_full = (edge_cnt == CNT_MAX);

    always_ff @(posedge clk100MHz) begin
        if (!rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_sat   <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else if (!enable) begin
            // Results hold; the window restarts from zero on re-enable.
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_sat   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (gate_end) begin
                // An edge on the terminal cycle still belongs to this window.
                freq_count <= (sig_edge && !cnt_full) ? edge_cnt + 1'b1 : edge_cnt;
                freq_ovf   <= edge_sat | (sig_edge & cnt_full);
                freq_valid <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                edge_sat   <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                if (sig_edge) begin
                    if (cnt_full) begin
                        edge_sat <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Period FSM
    // IDLE    : waiting for a first edge (or recovering after a timeout)
    // MEASURE : per_cnt counts cycles since the last edge
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_cnt_nx;
    logic [PER_W-1:0] period_count_nx;
    logic             period_valid_nx;
    logic             no_signal_nx;

    always_ff @(posedge clk100MHz) begin
        if (!rst) begin
            state        <= IDLE;
            per_cnt      <= '0;
            period_count <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            state        <= state_nx;
            per_cnt      <= per_cnt_nx;
            period_count <= period_count_nx;
            period_valid <= period_valid_nx;
            no_signal    <= no_signal_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        per_cnt_nx      = per_cnt;
        period_count_nx = period_count;
        period_valid_nx = 1'b0;
        no_signal_nx    = no_signal;

        if (!enable) begin
            state_nx   = IDLE;
            per_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    per_cnt_nx = '0;
                    if (sig_edge) begin
                        state_nx     = MEASURE;
                        no_signal_nx = 1'b0;
                    end
                end
                MEASURE: begin
                    // Edge is tested first so it wins over a simultaneous timeout.
                    if (sig_edge) begin
                        // per_cnt is zero on the cycle after an edge, so the
                        // distance between edges is per_cnt + 1.
                        period_count_nx = per_cnt + 1'b1;
                        period_valid_nx = 1'b1;
                        per_cnt_nx      = '0;
                    end else if (per_cnt == PER_LAST) begin
                        state_nx     = IDLE;
                        per_cnt_nx   = '0;
                        no_signal_nx = 1'b1;
                    end else begin
                        per_cnt_nx = per_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter (wide and 4-bit counter instances)

`timescale 1ns / 1ps

module tb_freq_meter;

    localparam int G    = 1000;
    localparam int TO   = 50;
    localparam int HMAX = 65536;

    logic        clk100MHz;
    logic        rst;
    logic        sig_in;
    logic        enable;

    logic [26:0] a_freq_count;
    logic        a_freq_valid;
    logic        a_freq_ovf;
    logic [31:0] a_period_count;
    logic        a_period_valid;
    logic        a_no_signal;

    logic [3:0]  b_freq_count;
    logic        b_freq_valid;
    logic        b_freq_ovf;
    logic [31:0] b_period_count;
    logic        b_period_valid;
    logic        b_no_signal;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(27), .PER_W(32), .TIMEOUT_CYCLES(TO)) u_wide (
        .clk100MHz    (clk100MHz),
        .rst          (rst),
        .sig_in       (sig_in),
        .enable       (enable),
        .freq_count   (a_freq_count),
        .freq_valid   (a_freq_valid),
        .freq_ovf     (a_freq_ovf),
        .period_count (a_period_count),
        .period_valid (a_period_valid),
        .no_signal    (a_no_signal)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .PER_W(32), .TIMEOUT_CYCLES(TO)) u_narrow (
        .clk100MHz    (clk100MHz),
        .rst          (rst),
        .sig_in       (sig_in),
        .enable       (enable),
        .freq_count   (b_freq_count),
        .freq_valid   (b_freq_valid),
        .freq_ovf     (b_freq_ovf),
        .period_count (b_period_count),
        .period_valid (b_period_valid),
        .no_signal    (b_no_signal)
    );

    typedef struct {
        int     cyc;
        longint val;
    } ev_t;

    ev_t fq[$];
    ev_t pq[$];
    ev_t nq[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  mon_on   = 0;

    // reference-model state visible to the stimulus
    bit     m_run       = 0;
    int     m_start     = 0;
    longint m_last_freq = 0;
    longint m_last_per  = 0;
    bit     m_ns        = 1;

    // waveform generator controls
    bit  wave_on    = 0;
    bit  manual_sig = 0;
    int  w_per      = 10;
    int  w_hi       = 5;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic longint ovf(input longint v, input int w);
        return (v > ((longint'(1) << w) - 1)) ? 1 : 0;
    endfunction

    initial begin
        clk100MHz = 1'b0;
        forever #5 clk100MHz = ~clk100MHz;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    // waveform generator: updates sig_in 2 ns after each rising clock edge
    initial begin
        int ph;
        ph     = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clk100MHz);
            #2;
            if (wave_on) begin
                sig_in = ((ph % w_per) < w_hi);
                ph++;
            end else begin
                sig_in = manual_sig;
                ph     = 0;
            end
        end
    end

    // Reference model, evaluated at each rising edge from the sampled inputs.
    // A rise present at edge k is reported by the meter at edge k+2.
    // Windows close every G edges counted from the first enabled edge; period
    // is the distance between detection cycles; timeout is TO cycles after the
    // last detection.
    initial begin
        bit hist [HMAX];
        bit det;
        int last_det;
        longint ecnt;
        bit meas;
        ecnt     = 0;
        meas     = 0;
        last_det = 0;
        forever begin
            @(posedge clk100MHz);
            cyc++;
            hist[cyc % HMAX] = sig_in;
            det = (cyc >= 3) && hist[(cyc - 2) % HMAX] && !hist[(cyc - 3) % HMAX];
            if (!rst) begin
                m_run       = 0;
                meas        = 0;
                ecnt        = 0;
                m_last_freq = 0;
                m_last_per  = 0;
                if (!m_ns) nq.push_back('{cyc, 1});
                m_ns = 1;
            end else if (!enable) begin
                m_run = 0;
                meas  = 0;
                ecnt  = 0;
            end else begin
                if (!m_run) begin
                    m_run   = 1;
                    m_start = cyc;
                    ecnt    = 0;
                end
                if (det) ecnt++;
                if ((cyc - m_start) % G == G - 1) begin
                    fq.push_back('{cyc, ecnt});
                    m_last_freq = ecnt;
                    ecnt        = 0;
                end
                if (meas) begin
                    if (det) begin
                        pq.push_back('{cyc, longint'(cyc - last_det)});
                        m_last_per = cyc - last_det;
                        last_det   = cyc;
                    end else if (cyc - last_det >= TO) begin
                        meas = 0;
                        nq.push_back('{cyc, 1});
                        m_ns = 1;
                    end
                end else if (det) begin
                    meas     = 1;
                    last_det = cyc;
                    if (m_ns) nq.push_back('{cyc, 0});
                    m_ns = 0;
                end
            end
        end
    end

    // Monitor: samples on the falling edge and pops expectations when outputs move.
    initial begin
        ev_t e;
        bit prev_a;
        bit prev_b;
        prev_a = 1;
        prev_b = 1;
        forever begin
            @(negedge clk100MHz);
            if (mon_on) begin
                if (a_freq_valid || b_freq_valid) begin
                    if (fq.size() == 0) begin
                        check("freq_valid_unexpected", a_freq_valid | b_freq_valid, 0);
                    end else begin
                        e = fq.pop_front();
                        check("freq_valid_cycle", cyc, e.cyc);
                        check("freq_valid_wide", a_freq_valid, 1);
                        check("freq_valid_narrow", b_freq_valid, 1);
                        check("freq_count_wide", a_freq_count, sat(e.val, 27));
                        check("freq_ovf_wide", a_freq_ovf, ovf(e.val, 27));
                        check("freq_count_narrow", b_freq_count, sat(e.val, 4));
                        check("freq_ovf_narrow", b_freq_ovf, ovf(e.val, 4));
                    end
                end
                while (fq.size() > 0 && fq[0].cyc < cyc) begin
                    e = fq.pop_front();
                    check("freq_valid_missing_at", cyc - 1, e.cyc);
                end

                if (a_period_valid || b_period_valid) begin
                    if (pq.size() == 0) begin
                        check("period_valid_unexpected", a_period_valid | b_period_valid, 0);
                    end else begin
                        e = pq.pop_front();
                        check("period_valid_cycle", cyc, e.cyc);
                        check("period_valid_wide", a_period_valid, 1);
                        check("period_valid_narrow", b_period_valid, 1);
                        check("period_count_wide", a_period_count, e.val);
                        check("period_count_narrow", b_period_count, e.val);
                    end
                end
                while (pq.size() > 0 && pq[0].cyc < cyc) begin
                    e = pq.pop_front();
                    check("period_valid_missing_at", cyc - 1, e.cyc);
                end

                if (a_no_signal !== prev_a || b_no_signal !== prev_b) begin
                    if (nq.size() == 0) begin
                        check("no_signal_unexpected_wide", a_no_signal, prev_a);
                        check("no_signal_unexpected_narrow", b_no_signal, prev_b);
                    end else begin
                        e = nq.pop_front();
                        check("no_signal_cycle", cyc, e.cyc);
                        check("no_signal_wide", a_no_signal, e.val);
                        check("no_signal_narrow", b_no_signal, e.val);
                    end
                    prev_a = a_no_signal;
                    prev_b = b_no_signal;
                end
                while (nq.size() > 0 && nq[0].cyc < cyc) begin
                    e = nq.pop_front();
                    check("no_signal_change_missing_at", cyc - 1, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk100MHz);
        #1;
    endtask

    task automatic chk_reset();
        check("rst_freq_count_wide", a_freq_count, 0);
        check("rst_freq_valid_wide", a_freq_valid, 0);
        check("rst_freq_ovf_wide", a_freq_ovf, 0);
        check("rst_period_count_wide", a_period_count, 0);
        check("rst_period_valid_wide", a_period_valid, 0);
        check("rst_no_signal_wide", a_no_signal, 1);
        check("rst_freq_count_narrow", b_freq_count, 0);
        check("rst_freq_valid_narrow", b_freq_valid, 0);
        check("rst_freq_ovf_narrow", b_freq_ovf, 0);
        check("rst_period_count_narrow", b_period_count, 0);
        check("rst_period_valid_narrow", b_period_valid, 0);
        check("rst_no_signal_narrow", b_no_signal, 1);
    endtask

    // Advance until edge (cyc + off) is a window-terminal edge.
    task automatic align(input int off);
        bit found;
        found = 0;
        for (int k = 0; k < 2 * G + 10; k++) begin
            if (m_run && ((cyc + off - m_start) % G == G - 1)) begin
                found = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL align_window: boundary not reached within %0d cycles", 2 * G + 10);
        end
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        repeat (5) tick();
        chk_reset();
        mon_on = 1;

        // steady 10-cycle square wave: freq 100 per window, period 10
        rst    = 1'b1;
        enable = 1'b1;
        w_per  = 10;
        w_hi   = 5;
        wave_on = 1;
        repeat (3500) tick();

        // exactly 8 edges in one window, then silence until timeout
        wave_on = 0;
        align(0);
        wave_on = 1;
        repeat (80) tick();
        wave_on = 0;
        repeat (100) tick();
        check("timeout_no_signal_wide", a_no_signal, 1);
        check("timeout_no_signal_narrow", b_no_signal, 1);
        check("timeout_period_hold_wide", a_period_count, 10);
        check("timeout_period_hold_narrow", b_period_count, 10);

        // resume
        align(0);
        wave_on = 1;
        repeat (500) tick();
        wave_on = 0;
        repeat (10) tick();

        // single edge detected on the terminal cycle of a window
        align(3);
        manual_sig = 1;
        repeat (4) tick();
        manual_sig = 0;
        repeat (1100) tick();

        // edge coinciding with timeout, then edges slower than timeout
        w_per = 50;
        w_hi  = 10;
        wave_on = 1;
        repeat (400) tick();
        w_per = 60;
        w_hi  = 30;
        repeat (400) tick();

        // random waveforms
        for (int i = 0; i < 6; i++) begin
            w_per = int'($urandom_range(70, 2));
            w_hi  = int'($urandom_range(w_per - 1, 1));
            repeat ($urandom_range(1500, 300)) tick();
        end

        // one-cycle reset mid-window
        w_per = 10;
        w_hi  = 5;
        repeat ($urandom_range(600, 100)) tick();
        rst = 1'b0;
        tick();
        chk_reset();
        rst = 1'b1;
        repeat (1500) tick();

        // enable low mid-window: results hold, no pulses
        w_per = int'($urandom_range(30, 4));
        w_hi  = w_per / 2;
        repeat ($urandom_range(700, 100)) tick();
        enable = 1'b0;
        repeat ($urandom_range(400, 50)) tick();
        check("hold_freq_count_wide", a_freq_count, sat(m_last_freq, 27));
        check("hold_freq_count_narrow", b_freq_count, sat(m_last_freq, 4));
        check("hold_freq_ovf_narrow", b_freq_ovf, ovf(m_last_freq, 4));
        check("hold_period_count_wide", a_period_count, m_last_per);
        check("hold_no_signal_wide", a_no_signal, m_ns);
        enable = 1'b1;
        repeat (2500) tick();

        wave_on = 0;
        repeat (200) tick();
        check("freq_events_drained", fq.size(), 0);
        check("period_events_drained", pq.size(), 0);
        check("no_signal_events_drained", nq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
